// File: rtl/pc_branch_unit.sv
// Program counter, flag register and return-address stack; resolves decoder branch strobes into the next fetch address.
// Redirects and flag writes land one cycle after the retiring edge; adv=0 stalls all state while taken stays live.
module pc_branch_unit #(
    parameter int AW        = 32,
    parameter int PC_INC    = 4,
    parameter int RESET_PC  = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         adv,
    input  logic                         b,
    input  logic                         br,
    input  logic                         bz,
    input  logic                         bnz,
    input  logic                         bcy,
    input  logic                         bncy,
    input  logic                         bs,
    input  logic                         bns,
    input  logic                         bv,
    input  logic                         bnv,
    input  logic                         Call,
    input  logic                         Ret,
    input  logic [AW-1:0]                offset,
    input  logic [AW-1:0]                rs_val,
    input  logic                         flag_we,
    input  logic                         alu_c,
    input  logic                         alu_z,
    input  logic                         alu_s,
    input  logic                         alu_v,
    output logic [AW-1:0]                pc,
    output logic                         taken,
    output logic [3:0]                   flags,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_err
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_pc;
    logic [3:0]    r_flags;
    logic [AW-1:0] r_stack [RAS_DEPTH];
    logic [PW-1:0] r_top;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic [AW-1:0] w_seq;
    logic [AW-1:0] w_rel;
    logic [AW-1:0] w_next;
    logic [PW-1:0] w_top_m1;
    logic          w_cond;
    logic          w_full;
    logic          w_empty;
    logic          w_taken;
    logic          w_push;
    logic          w_pop;
    logic          w_err_set;
    logic          w_c, w_z, w_s, w_v;

    assign {w_c, w_z, w_s, w_v} = r_flags;

    assign w_seq    = r_pc + AW'(PC_INC);
    assign w_rel    = r_pc + offset;
    assign w_top_m1 = r_top - PW'(1);
    assign w_full   = (r_count == CW'(RAS_DEPTH));
    assign w_empty  = (r_count == '0);

    // Conditions look only at the registered flags, so a same-cycle flag write is not seen.
    assign w_cond = (bz   &  w_z) | (bnz  & ~w_z) |
                    (bcy  &  w_c) | (bncy & ~w_c) |
                    (bs   &  w_s) | (bns  & ~w_s) |
                    (bv   &  w_v) | (bnv  & ~w_v);

    // Priority Ret > Call > br > b > conditionals; only the winner acts.
    always_comb begin
        w_next    = w_seq;
        w_taken   = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        if (Ret) begin
            if (w_empty) begin
                w_err_set = 1'b1;
            end else begin
                w_next  = r_stack[w_top_m1];
                w_taken = 1'b1;
                w_pop   = 1'b1;
            end
        end else if (Call) begin
            w_next    = w_rel;
            w_taken   = 1'b1;
            w_push    = 1'b1;
            w_err_set = w_full;
        end else if (br) begin
            w_next  = rs_val;
            w_taken = 1'b1;
        end else if (b || w_cond) begin
            w_next  = w_rel;
            w_taken = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= AW'(RESET_PC);
            r_flags <= '0;
            r_top   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (adv) begin
            r_pc <= w_next;
            if (flag_we) begin
                r_flags <= {alu_c, alu_z, alu_s, alu_v};
            end
            // A push into a full stack lands on the oldest slot, which the wrapped top already points at.
            if (w_push) begin
                r_stack[r_top] <= w_seq;
                r_top          <= r_top + PW'(1);
                if (!w_full) begin
                    r_count <= r_count + CW'(1);
                end
            end
            if (w_pop) begin
                r_top   <= w_top_m1;
                r_count <= r_count - CW'(1);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pc        = r_pc;
    assign taken     = w_taken;
    assign flags     = r_flags;
    assign ras_count = r_count;
    assign ras_err   = r_err;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed-vector bench for pc_branch_unit with a queue-based scoreboard and an independent monitor process.
module tb_pc_branch_unit;

    localparam int AW = 32;

    localparam logic [11:0] S_NONE = 12'h000;
    localparam logic [11:0] S_B    = 12'h800;
    localparam logic [11:0] S_BR   = 12'h400;
    localparam logic [11:0] S_BZ   = 12'h200;
    localparam logic [11:0] S_BNZ  = 12'h100;
    localparam logic [11:0] S_BCY  = 12'h080;
    localparam logic [11:0] S_BNCY = 12'h040;
    localparam logic [11:0] S_BS   = 12'h020;
    localparam logic [11:0] S_BNS  = 12'h010;
    localparam logic [11:0] S_BV   = 12'h008;
    localparam logic [11:0] S_BNV  = 12'h004;
    localparam logic [11:0] S_CALL = 12'h002;
    localparam logic [11:0] S_RET  = 12'h001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          adv;
    logic [11:0]   st;
    logic [AW-1:0] offset;
    logic [AW-1:0] rs_val;
    logic          flag_we;
    logic [3:0]    alu_f;
    logic [AW-1:0] pc;
    logic          taken;
    logic [3:0]    flags;
    logic [2:0]    ras_count;
    logic          ras_err;

    pc_branch_unit #(.AW(AW), .PC_INC(4), .RESET_PC(0), .RAS_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (adv),
        .b         (st[11]),
        .br        (st[10]),
        .bz        (st[9]),
        .bnz       (st[8]),
        .bcy       (st[7]),
        .bncy      (st[6]),
        .bs        (st[5]),
        .bns       (st[4]),
        .bv        (st[3]),
        .bnv       (st[2]),
        .Call      (st[1]),
        .Ret       (st[0]),
        .offset    (offset),
        .rs_val    (rs_val),
        .flag_we   (flag_we),
        .alu_c     (alu_f[3]),
        .alu_z     (alu_f[2]),
        .alu_s     (alu_f[1]),
        .alu_v     (alu_f[0]),
        .pc        (pc),
        .taken     (taken),
        .flags     (flags),
        .ras_count (ras_count),
        .ras_err   (ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic          taken;
        logic [AW-1:0] pc;
        logic [3:0]    flags;
        logic [2:0]    cnt;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    event obs_ev;
    int   tests   = 0;
    int   fails   = 0;
    int   pushed  = 0;
    int   popped  = 0;
    int   step_id = 0;

    task automatic expect_now(input logic et, input logic [AW-1:0] epc, input logic [3:0] ef,
                              input logic [2:0] ec, input logic ee);
        exp_t e;
        e.id = step_id; e.taken = et; e.pc = epc; e.flags = ef; e.cnt = ec; e.err = ee;
        exp_q.push_back(e);
        pushed++;
        step_id++;
        -> obs_ev;
    endtask

    // Inputs applied on the falling edge; expectations describe the outputs seen before the next rising edge.
    task automatic step(input logic a, input logic [11:0] s, input logic [AW-1:0] off,
                        input logic [AW-1:0] rs, input logic fwe, input logic [3:0] af,
                        input logic et, input logic [AW-1:0] epc, input logic [3:0] ef,
                        input logic [2:0] ec, input logic ee);
        @(negedge clk);
        adv = a; st = s; offset = off; rs_val = rs; flag_we = fwe; alu_f = af;
        #1;
        expect_now(et, epc, ef, ec, ee);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(obs_ev);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty: observation with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                popped++;
                if (taken !== e.taken) begin
                    fails++;
                    $display("FAIL step%0d taken: got %b expected %b", e.id, taken, e.taken);
                end
                tests++;
                if (pc !== e.pc) begin
                    fails++;
                    $display("FAIL step%0d pc: got %h expected %h", e.id, pc, e.pc);
                end
                tests++;
                if (flags !== e.flags) begin
                    fails++;
                    $display("FAIL step%0d flags: got %b expected %b", e.id, flags, e.flags);
                end
                tests++;
                if (ras_count !== e.cnt) begin
                    fails++;
                    $display("FAIL step%0d ras_count: got %0d expected %0d", e.id, ras_count, e.cnt);
                end
                tests++;
                if (ras_err !== e.err) begin
                    fails++;
                    $display("FAIL step%0d ras_err: got %b expected %b", e.id, ras_err, e.err);
                end
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; adv = 1'b0; st = S_NONE; offset = '0; rs_val = '0; flag_we = 1'b0; alu_f = '0;
        #2;
        expect_now(1'b0, 32'h0, 4'b0000, 3'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // sequential flow
        step(1, S_NONE, 0, 0, 0, 4'b0000, 0, 32'h0,  4'b0000, 0, 0);
        step(1, S_NONE, 0, 0, 0, 4'b0000, 0, 32'h4,  4'b0000, 0, 0);
        step(1, S_NONE, 0, 0, 0, 4'b0000, 0, 32'h8,  4'b0000, 0, 0);
        step(1, S_BR,   0, 32'h1C, 0, 4'b0000, 1, 32'hC, 4'b0000, 0, 0);
        // flag write then bz / bnz
        step(1, S_NONE, 0, 0, 1, 4'b0100, 0, 32'h1C, 4'b0000, 0, 0);
        step(1, S_BZ,   32'h40, 0, 0, 4'b0000, 1, 32'h20, 4'b0100, 0, 0);
        step(1, S_BNZ,  32'h40, 0, 0, 4'b0000, 0, 32'h60, 4'b0100, 0, 0);
        step(1, S_BR,   0, 32'h100, 1, 4'b0000, 1, 32'h64, 4'b0100, 0, 0);
        // same-cycle flag write and bz: branch sees old z=0
        step(1, S_BZ,   32'h40, 0, 1, 4'b0100, 0, 32'h100, 4'b0000, 0, 0);
        // stalled: taken live, state holds
        step(0, S_BZ,   32'h40, 0, 0, 4'b0000, 1, 32'h104, 4'b0100, 0, 0);
        step(1, S_BR,   0, 32'h10, 0, 4'b0000, 1, 32'h104, 4'b0100, 0, 0);
        // call / return
        step(1, S_CALL, 32'h100, 0, 0, 4'b0000, 1, 32'h10,  4'b0100, 0, 0);
        step(1, S_RET,  0, 0, 0, 4'b0000, 1, 32'h110, 4'b0100, 1, 0);
        step(1, S_BR,   0, 32'h0, 0, 4'b0000, 1, 32'h14,  4'b0100, 0, 0);
        // overflow with five calls
        step(1, S_CALL, 32'h100, 0, 0, 4'b0000, 1, 32'h0,   4'b0100, 0, 0);
        step(1, S_CALL, 32'h100, 0, 0, 4'b0000, 1, 32'h100, 4'b0100, 1, 0);
        step(1, S_CALL, 32'h100, 0, 0, 4'b0000, 1, 32'h200, 4'b0100, 2, 0);
        step(1, S_CALL, 32'h100, 0, 0, 4'b0000, 1, 32'h300, 4'b0100, 3, 0);
        step(1, S_CALL, 32'h100, 0, 0, 4'b0000, 1, 32'h400, 4'b0100, 4, 0);
        step(1, S_RET,  0, 0, 0, 4'b0000, 1, 32'h500, 4'b0100, 4, 1);
        step(1, S_RET,  0, 0, 0, 4'b0000, 1, 32'h404, 4'b0100, 3, 1);
        step(1, S_RET,  0, 0, 0, 4'b0000, 1, 32'h304, 4'b0100, 2, 1);
        step(1, S_RET,  0, 0, 0, 4'b0000, 1, 32'h204, 4'b0100, 1, 1);
        // underflow: not taken, falls through
        step(1, S_RET,  0, 0, 0, 4'b0000, 0, 32'h104, 4'b0100, 0, 1);
        // br beats b
        step(1, S_BR | S_B, 32'h8, 32'hDEADBEE0, 0, 4'b0000, 1, 32'h108, 4'b0100, 0, 1);
        step(0, S_B,    32'h8, 0, 0, 4'b0000, 1, 32'hDEADBEE0, 4'b0100, 0, 1);
        step(0, S_NONE, 0, 0, 0, 4'b0000, 0, 32'hDEADBEE0, 4'b0100, 0, 1);
        // remaining condition codes with c=1 z=0 s=1 v=1
        step(1, S_NONE, 0, 0, 1, 4'b1011, 0, 32'hDEADBEE0, 4'b0100, 0, 1);
        step(1, S_BCY,  32'h10, 0, 0, 4'b0000, 1, 32'hDEADBEE4, 4'b1011, 0, 1);
        step(1, S_BNCY, 32'h10, 0, 0, 4'b0000, 0, 32'hDEADBEF4, 4'b1011, 0, 1);
        step(1, S_BS,   32'hFFFFFFF8, 0, 0, 4'b0000, 1, 32'hDEADBEF8, 4'b1011, 0, 1);
        step(1, S_BNS,  32'h10, 0, 0, 4'b0000, 0, 32'hDEADBEF0, 4'b1011, 0, 1);
        step(1, S_BV,   32'h8,  0, 0, 4'b0000, 1, 32'hDEADBEF4, 4'b1011, 0, 1);
        step(1, S_BNV,  32'h8,  0, 0, 4'b0000, 0, 32'hDEADBEFC, 4'b1011, 0, 1);
        // Ret wins over Call and b even when it underflows
        step(1, S_RET | S_CALL | S_B, 32'h100, 0, 0, 4'b0000, 0, 32'hDEADBF00, 4'b1011, 0, 1);
        step(1, S_CALL | S_B | S_BZ,  32'h20,  0, 0, 4'b0000, 1, 32'hDEADBF04, 4'b1011, 0, 1);
        // address wrap-around
        step(1, S_BR,   0, 32'hFFFFFFFC, 0, 4'b0000, 1, 32'hDEADBF24, 4'b1011, 1, 1);
        step(1, S_NONE, 0, 0, 0, 4'b0000, 0, 32'hFFFFFFFC, 4'b1011, 1, 1);
        // reset asserted between edges while a Call is presented
        step(1, S_CALL, 32'h40, 0, 0, 4'b0000, 1, 32'h0, 4'b1011, 1, 1);
        #1 rst_n = 1'b0;
        #1 expect_now(1'b1, 32'h0, 4'b0000, 3'd0, 1'b0);
        #1 adv = 1'b0; st = S_NONE;
        #1 rst_n = 1'b1;
        step(1, S_NONE, 0, 0, 0, 4'b0000, 0, 32'h0, 4'b0000, 0, 0);
        step(0, S_NONE, 0, 0, 0, 4'b0000, 0, 32'h4, 4'b0000, 0, 0);

        #3;
        tests++;
        if (popped != pushed || exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: popped %0d of %0d pushed", popped, pushed);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
